// File: rtl/inst_fetch_unit_pkg.sv
// Shared defaults, pointer-width helper and FSM encoding for the instruction
// fetch unit and its fetch queue.
package inst_fetch_unit_pkg;

  localparam int FQ_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    FETCH_RUN   = 2'd0,
    FETCH_HOLD  = 2'd1,
    FETCH_FLUSH = 2'd2
  } fetch_state_e;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/inst_fetch_unit_queue.sv
// In-order circular fetch queue of {pc, inst} entries: paired push, 0/1/2 pop,
// synchronous clear, and head/head+1 presented with valid flags.
module fetch_queue
  import inst_fetch_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = FQ_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        push_pc1_i,
  input  logic [DATA_W-1:0]        push_inst1_i,
  input  logic [DATA_W-1:0]        push_pc2_i,
  input  logic [DATA_W-1:0]        push_inst2_i,
  input  logic [1:0]               pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     head_valid1_o,
  output logic                     head_valid2_o,
  output logic [DATA_W-1:0]        head_pc1_o,
  output logic [DATA_W-1:0]        head_inst1_o,
  output logic [DATA_W-1:0]        head_pc2_o,
  output logic [DATA_W-1:0]        head_inst2_o
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] pc_mem_q   [DEPTH];
  logic [DATA_W-1:0] inst_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers are exactly PTR_W bits wide, so wrap modulo DEPTH is free.
  always_comb begin
    wr_ptr_nxt = wr_ptr_q + PTR_W'(1);
    rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(2);
      end
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
      count_d  = count_q + (push_i ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) begin
      pc_mem_q[wr_ptr_q]     <= push_pc1_i;
      inst_mem_q[wr_ptr_q]   <= push_inst1_i;
      pc_mem_q[wr_ptr_nxt]   <= push_pc2_i;
      inst_mem_q[wr_ptr_nxt] <= push_inst2_i;
    end
  end

  // Invalid slots read as zero so stale storage never leaks to decode.
  assign count_o       = count_q;
  assign head_valid1_o = (count_q != '0);
  assign head_valid2_o = (count_q > CNT_W'(1));
  assign head_pc1_o    = head_valid1_o ? pc_mem_q[rd_ptr_q]     : '0;
  assign head_inst1_o  = head_valid1_o ? inst_mem_q[rd_ptr_q]   : '0;
  assign head_pc2_o    = head_valid2_o ? pc_mem_q[rd_ptr_nxt]   : '0;
  assign head_inst2_o  = head_valid2_o ? inst_mem_q[rd_ptr_nxt] : '0;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (push_i && !clear_i) |-> (count_q <= CNT_W'(DEPTH - 2)));

endmodule

// File: rtl/inst_fetch_unit.sv
// Two-wide instruction fetch: owns the fetch PC, drives the instruction-memory
// request and feeds decode from the fetch queue; redirects flush and refetch.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                FQ_DEPTH = FQ_DEPTH_DEF,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] inst_address,
  output logic              InstMem_Read,
  input  logic              InstMem_Ready,
  input  logic [DATA_W-1:0] inst1_in,
  input  logic [DATA_W-1:0] inst2_in,
  output logic              dec_valid1,
  output logic              dec_valid2,
  output logic [DATA_W-1:0] dec_inst1,
  output logic [DATA_W-1:0] dec_inst2,
  output logic [DATA_W-1:0] dec_pc1,
  output logic [DATA_W-1:0] dec_pc2,
  input  logic [1:0]        dec_accept,
  input  logic              redirect_valid,
  input  logic [DATA_W-1:0] redirect_pc
);

  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  fq_count;
  logic [CNT_W-1:0]  free;
  logic              read_req;
  logic              transfer;
  logic              fq_push;
  logic [1:0]        fq_pop;
  logic [1:0]        valid_cnt;

  // Free space is taken before this cycle's pop, so the request is conservative.
  assign free     = CNT_W'(FQ_DEPTH) - fq_count;
  assign transfer = read_req && InstMem_Ready;
  assign fq_push  = transfer && !redirect_valid;
  assign fq_pop   = redirect_valid ? 2'b00 : dec_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      state_d = FETCH_FLUSH;
      pc_d    = redirect_pc & ~DATA_W'(3);
    end else begin
      case (state_q)
        FETCH_RUN: begin
          if (read_req && !InstMem_Ready) begin
            state_d = FETCH_HOLD;
          end else if (transfer) begin
            pc_d = pc_q + DATA_W'(8);
          end
        end
        FETCH_HOLD: begin
          if (InstMem_Ready) begin
            state_d = FETCH_RUN;
            pc_d    = pc_q + DATA_W'(8);
          end
        end
        FETCH_FLUSH: state_d = FETCH_RUN;
        default:     state_d = FETCH_RUN;
      endcase
    end
  end

  // Request depends only on registered state; HOLD keeps it up until Ready.
  always_comb begin
    read_req = 1'b0;
    case (state_q)
      FETCH_RUN:   read_req = (free >= CNT_W'(2));
      FETCH_HOLD:  read_req = 1'b1;
      FETCH_FLUSH: read_req = 1'b0;
      default:     read_req = 1'b0;
    endcase
  end

  assign InstMem_Read = read_req & ~rst;
  assign inst_address = pc_q;

  fetch_queue #(
    .DATA_W (DATA_W),
    .DEPTH  (FQ_DEPTH)
  ) u_fetch_queue (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (redirect_valid),
    .push_i        (fq_push),
    .push_pc1_i    (pc_q),
    .push_inst1_i  (inst1_in),
    .push_pc2_i    (pc_q + DATA_W'(4)),
    .push_inst2_i  (inst2_in),
    .pop_i         (fq_pop),
    .count_o       (fq_count),
    .head_valid1_o (dec_valid1),
    .head_valid2_o (dec_valid2),
    .head_pc1_o    (dec_pc1),
    .head_inst1_o  (dec_inst1),
    .head_pc2_o    (dec_pc2),
    .head_inst2_o  (dec_inst2)
  );

  assign valid_cnt = {1'b0, dec_valid1} + {1'b0, dec_valid2};

  a_accept_legal: assert property (@(posedge clk) disable iff (rst)
    !redirect_valid |-> (dec_accept <= valid_cnt));

  a_valid_order: assert property (@(posedge clk) disable iff (rst)
    dec_valid2 |-> dec_valid1);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: vector table from reset, then
// scoreboard-driven sequences for stall, hold+redirect, wrap and mid-run reset.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_address;
  logic        InstMem_Read;
  logic        InstMem_Ready;
  logic [31:0] inst1_in, inst2_in;
  logic        dec_valid1, dec_valid2;
  logic [31:0] dec_inst1, dec_inst2, dec_pc1, dec_pc2;
  logic [1:0]  dec_accept;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .DATA_W   (32),
    .FQ_DEPTH (8),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .inst_address   (inst_address),
    .InstMem_Read   (InstMem_Read),
    .InstMem_Ready  (InstMem_Ready),
    .inst1_in       (inst1_in),
    .inst2_in       (inst2_in),
    .dec_valid1     (dec_valid1),
    .dec_valid2     (dec_valid2),
    .dec_inst1      (dec_inst1),
    .dec_inst2      (dec_inst2),
    .dec_pc1        (dec_pc1),
    .dec_pc2        (dec_pc2),
    .dec_accept     (dec_accept),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  // Responder memory holds mem[i] = i, i.e. the word at address a is a/4.
  assign inst1_in = inst_address >> 2;
  assign inst2_in = (inst_address >> 2) + 32'd1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef struct {
    logic        rdy;
    logic [1:0]  acc;
    logic        redir;
    logic [31:0] rpc;
    logic        expRead;
    logic [31:0] expAddr;
    logic        expV1;
    logic        expV2;
    logic [31:0] expPc1;
  } vec_t;

  entry_t      sbq[$];
  vec_t        vecs[12];
  int          errors = 0;
  int          checks = 0;
  int          dutTransfers = 0;
  logic        holdFlag, flushFlag;
  logic [31:0] expFetchPc, expNextDecPc;

  function automatic logic expRead();
    return !flushFlag && (holdFlag || sbq.size() <= 6);
  endfunction

  function automatic logic [1:0] legalAcc(input int want);
    int n;
    n = sbq.size();
    if (want > n) want = n;
    return 2'(want);
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic er;
    er = expRead();
    checkVal("read", {31'd0, InstMem_Read}, {31'd0, er});
    checkVal("addr", inst_address, expFetchPc);
    checkVal("valid1", {31'd0, dec_valid1}, {31'd0, sbq.size() >= 1});
    checkVal("valid2", {31'd0, dec_valid2}, {31'd0, sbq.size() >= 2});
    if (sbq.size() >= 1) begin
      checkVal("pc1", dec_pc1, sbq[0].pc);
      checkVal("inst1", dec_inst1, sbq[0].inst);
    end
    if (sbq.size() >= 2) begin
      checkVal("pc2", dec_pc2, sbq[1].pc);
      checkVal("inst2", dec_inst2, sbq[1].inst);
    end
  endtask

  task automatic resetModel();
    sbq.delete();
    holdFlag     = 1'b0;
    flushFlag    = 1'b0;
    expFetchPc   = RESET_PC;
    expNextDecPc = RESET_PC;
  endtask

  // One cycle: check outputs at the negedge, drive inputs, update the model,
  // then wait for the next negedge.
  task automatic applyStimulus(input logic rdy, input logic [1:0] acc,
                               input logic redir, input logic [31:0] rpc);
    logic er;
    checkOutput();
    er = expRead();
    if (InstMem_Read && rdy && !redir) dutTransfers++;
    InstMem_Ready  = rdy;
    dec_accept     = acc;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (redir) begin
      sbq.delete();
      flushFlag    = 1'b1;
      holdFlag     = 1'b0;
      expFetchPc   = rpc & ~32'h3;
      expNextDecPc = expFetchPc;
    end else begin
      for (int k = 0; k < int'(acc); k++) begin
        if (sbq.size() > 0) begin
          if (k == 0) checkVal("seq_pc1", dec_pc1, expNextDecPc);
          else        checkVal("seq_pc2", dec_pc2, expNextDecPc);
          expNextDecPc = expNextDecPc + 32'd4;
          void'(sbq.pop_front());
        end
      end
      flushFlag = 1'b0;
      if (er && rdy) begin
        sbq.push_back('{pc: expFetchPc, inst: expFetchPc >> 2});
        sbq.push_back('{pc: expFetchPc + 32'd4, inst: (expFetchPc >> 2) + 32'd1});
        expFetchPc = expFetchPc + 32'd8;
        holdFlag   = 1'b0;
      end else if (er && !rdy) begin
        holdFlag = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    int pat[4];
    pat = '{1, 2, 1, 0};

    //           rdy   acc   redir rpc           read  addr          v1    v2    pc1
    vecs[0]  = '{1'b1, 2'd0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 2'd2, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 1'b1, 32'h0};
    vecs[2]  = '{1'b1, 2'd2, 1'b0, 32'h0,        1'b1, 32'h10,       1'b1, 1'b1, 32'h8};
    vecs[3]  = '{1'b0, 2'd2, 1'b0, 32'h0,        1'b1, 32'h18,       1'b1, 1'b1, 32'h10};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 32'h18,       1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 2'd0, 1'b0, 32'h0,        1'b1, 32'h18,       1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 2'd1, 1'b0, 32'h0,        1'b1, 32'h20,       1'b1, 1'b1, 32'h18};
    vecs[7]  = '{1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 32'h28,       1'b1, 1'b1, 32'h1c};
    vecs[8]  = '{1'b1, 2'd2, 1'b1, 32'h1003,     1'b1, 32'h28,       1'b1, 1'b1, 32'h1c};
    vecs[9]  = '{1'b1, 2'd0, 1'b0, 32'h0,        1'b0, 32'h1000,     1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 2'd0, 1'b0, 32'h0,        1'b1, 32'h1000,     1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h0,        1'b1, 32'h1008,     1'b1, 1'b1, 32'h1000};

    rst            = 1'b1;
    InstMem_Ready  = 1'b0;
    dec_accept     = 2'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    resetModel();
    @(negedge clk);
    @(negedge clk);

    checkVal("rst_read", {31'd0, InstMem_Read}, 32'd0);
    checkVal("rst_addr", inst_address, RESET_PC);
    checkVal("rst_valid1", {31'd0, dec_valid1}, 32'd0);
    checkVal("rst_valid2", {31'd0, dec_valid2}, 32'd0);
    checkVal("rst_inst1", dec_inst1, 32'd0);
    checkVal("rst_pc2", dec_pc2, 32'd0);

    rst = 1'b0;
    #1;

    // Vector table from reset: hold, redirect while holding, refetch.
    for (int i = 0; i < 12; i++) begin
      checkVal($sformatf("vec%0d_read", i), {31'd0, InstMem_Read}, {31'd0, vecs[i].expRead});
      checkVal($sformatf("vec%0d_addr", i), inst_address, vecs[i].expAddr);
      checkVal($sformatf("vec%0d_v1", i), {31'd0, dec_valid1}, {31'd0, vecs[i].expV1});
      checkVal($sformatf("vec%0d_v2", i), {31'd0, dec_valid2}, {31'd0, vecs[i].expV2});
      checkVal($sformatf("vec%0d_pc1", i), dec_pc1, vecs[i].expPc1);
      checkVal($sformatf("vec%0d_inst1", i), dec_inst1, vecs[i].expPc1 >> 2);
      applyStimulus(vecs[i].rdy, vecs[i].acc, vecs[i].redir, vecs[i].rpc);
    end

    // Decode stalled: exactly four pairs fit, then the request drops.
    dutTransfers = 0;
    repeat (12) applyStimulus(1'b1, 2'd0, 1'b0, 32'h0);
    checkVal("stall_xfers", dutTransfers, 32'd4);
    checkVal("stall_read", {31'd0, InstMem_Read}, 32'd0);
    checkVal("stall_valid2", {31'd0, dec_valid2}, 32'd1);

    waited = 0;
    while (InstMem_Read !== 1'b1 && waited < 10) begin
      applyStimulus(1'b1, 2'd1, 1'b0, 32'h0);
      waited++;
    end
    checkVal("refill_cycles", waited, 32'd2);

    // Enter HOLD, then redirect in the same cycle the response arrives.
    applyStimulus(1'b0, legalAcc(2), 1'b0, 32'h0);
    applyStimulus(1'b0, legalAcc(2), 1'b0, 32'h0);
    checkVal("hold_read", {31'd0, InstMem_Read}, 32'd1);
    applyStimulus(1'b1, 2'd0, 1'b1, 32'h2003);
    checkVal("redir_valid1", {31'd0, dec_valid1}, 32'd0);
    checkVal("redir_flush_read", {31'd0, InstMem_Read}, 32'd0);
    applyStimulus(1'b1, 2'd0, 1'b0, 32'h0);
    checkVal("redir_read", {31'd0, InstMem_Read}, 32'd1);
    checkVal("redir_addr", inst_address, 32'h2000);

    // Long run with accept pattern 1,2,1,0: pointers wrap many times.
    for (int c = 0; c < 200; c++) begin
      applyStimulus(1'b1, legalAcc(pat[c % 4]), 1'b0, 32'h0);
    end

    // Steer occupancy to five entries, then reset asynchronously.
    waited = 0;
    while (sbq.size() != 5 && waited < 40) begin
      if (sbq.size() > 5) applyStimulus(1'b0, (sbq.size() - 5 >= 2) ? 2'd2 : 2'd1, 1'b0, 32'h0);
      else                applyStimulus(1'b1, legalAcc(1), 1'b0, 32'h0);
      waited++;
    end
    if (sbq.size() != 5) begin
      checks++;
      errors++;
      $display("[TB] FAIL reach_count5: occupancy %0d, wanted 5", sbq.size());
    end
    checkVal("pre_rst_valid2", {31'd0, dec_valid2}, 32'd1);
    InstMem_Ready = 1'b0;
    dec_accept    = 2'd0;
    rst           = 1'b1;
    #1;
    checkVal("midrst_valid1", {31'd0, dec_valid1}, 32'd0);
    checkVal("midrst_valid2", {31'd0, dec_valid2}, 32'd0);
    checkVal("midrst_addr", inst_address, RESET_PC);
    checkVal("midrst_read", {31'd0, InstMem_Read}, 32'd0);
    @(negedge clk);
    checkVal("midrst_read_held", {31'd0, InstMem_Read}, 32'd0);
    rst = 1'b0;
    resetModel();
    #1;
    repeat (6) applyStimulus(1'b1, legalAcc(2), 1'b0, 32'h0);
    checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
